mem_copy_engine: RTL and testbench

//  Block-copy DMA initiator driving the read/write ports of the word-addressable memory model.

---
 rtl/mem_copy_engine.sv | 154 +++++++++++++++
 tb/tb_mem_copy_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Block-copy DMA initiator: streams len words from src to dst, one word per cycle.
// Optional running checksum of written words when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine #(
   parameter int unsigned MEM_WORDS = 65536
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic [31:0] len,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] xfer_count,
   output logic [31:0] checksum,
   output logic        mem_read_en,
   output logic [31:0] mem_read_addr,
   input  logic [31:0] mem_read_data,
   output logic        mem_write_en,
   output logic [31:0] mem_write_addr,
   output logic [31:0] mem_write_data
);

   typedef enum logic [1:0] {StIdle, StCopy, StDrain, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] src_q, src_d;
   logic [31:0] dst_q, dst_d;
   logic [31:0] len_q, len_d;
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] xfer_q, xfer_d;
   logic        err_q, err_d;

   logic [32:0] src_end;
   logic [32:0] dst_end;
   logic [32:0] mem_limit;
   logic        cmd_err;

   // 33-bit sums so a wrapping src+len cannot slip past the range check
   assign mem_limit = 33'(MEM_WORDS);
   assign src_end   = {1'b0, src_addr} + {1'b0, len};
   assign dst_end   = {1'b0, dst_addr} + {1'b0, len};
   assign cmd_err   = (src_end > mem_limit) || (dst_end > mem_limit) ||
                      ((dst_addr > src_addr) && ({1'b0, dst_addr} < src_end));

   always_comb begin
      state_d        = state_q;
      src_d          = src_q;
      dst_d          = dst_q;
      len_d          = len_q;
      rd_cnt_d       = rd_cnt_q;
      xfer_d         = xfer_q;
      err_d          = err_q;
      mem_read_en    = 1'b0;
      mem_read_addr  = 32'd0;
      mem_write_en   = 1'b0;
      mem_write_addr = 32'd0;
      mem_write_data = 32'd0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               src_d    = src_addr;
               dst_d    = dst_addr;
               len_d    = len;
               rd_cnt_d = 32'd0;
               xfer_d   = 32'd0;
               err_d    = cmd_err;
               state_d  = (cmd_err || (len == 32'd0)) ? StDone : StCopy;
            end
         end
         StCopy: begin
            mem_read_en   = 1'b1;
            mem_read_addr = src_q + rd_cnt_q;
            rd_cnt_d      = rd_cnt_q + 32'd1;
            // Data from the previous cycle's read is written straight through
            if (rd_cnt_q != 32'd0) begin
               mem_write_en   = 1'b1;
               mem_write_addr = dst_q + xfer_q;
               mem_write_data = mem_read_data;
               xfer_d         = xfer_q + 32'd1;
            end
            if (abort || (rd_cnt_d == len_q)) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            mem_write_en   = 1'b1;
            mem_write_addr = dst_q + xfer_q;
            mem_write_data = mem_read_data;
            xfer_d         = xfer_q + 32'd1;
            state_d        = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         src_q    <= 32'd0;
         dst_q    <= 32'd0;
         len_q    <= 32'd0;
         rd_cnt_q <= 32'd0;
         xfer_q   <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         rd_cnt_q <= rd_cnt_d;
         xfer_q   <= xfer_d;
         err_q    <= err_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign err        = (state_q == StDone) && err_q;
   assign xfer_count = xfer_q;

`ifdef MEM_COPY_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if ((state_q == StIdle) && start) begin
         checksum_d = 32'd0;
      end else if (mem_write_en) begin
         checksum_d = checksum_q + mem_write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum_q <= 32'd0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 64K-word synchronous memory model.
// Checksum expectation follows MEM_COPY_CHECKSUM_EN.
module tb_mem_copy_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src_addr = 32'd0;
   logic [31:0] dst_addr = 32'd0;
   logic [31:0] len = 32'd0;
   logic        abort = 1'b0;
   logic        busy, done, err;
   logic [31:0] xfer_count, checksum;
   logic        mem_read_en, mem_write_en;
   logic [31:0] mem_read_addr, mem_write_addr, mem_write_data;
   logic [31:0] mem_read_data = 32'd0;

   logic [31:0] mem [0:65535];
   logic        pre_we = 1'b0;
   logic [15:0] pre_addr = 16'd0;
   logic [31:0] pre_data = 32'd0;
   int          rd_total = 0;
   int          wr_total = 0;
   int          done_total = 0;

   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mem_copy_engine #(.MEM_WORDS(65536)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .src_addr       (src_addr),
      .dst_addr       (dst_addr),
      .len            (len),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .xfer_count     (xfer_count),
      .checksum       (checksum),
      .mem_read_en    (mem_read_en),
      .mem_read_addr  (mem_read_addr),
      .mem_read_data  (mem_read_data),
      .mem_write_en   (mem_write_en),
      .mem_write_addr (mem_write_addr),
      .mem_write_data (mem_write_data)
   );

   always @(posedge clk) begin
      if (mem_read_en) mem_read_data <= mem[mem_read_addr[15:0]];
      if (mem_write_en) mem[mem_write_addr[15:0]] <= mem_write_data;
      if (pre_we) mem[pre_addr] <= pre_data;
      if (mem_read_en) rd_total <= rd_total + 1;
      if (mem_write_en) wr_total <= wr_total + 1;
      if (done) done_total <= done_total + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Returns cycles from the start cycle T to the cycle where done is seen.
   task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n,
                      output int lat, output logic b1);
      @(negedge clk);
      start = 1'b1;
      src_addr = s;
      dst_addr = d;
      len = n;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      b1 = busy;
      while (done !== 1'b1 && lat < 300) begin
         @(negedge clk);
         lat++;
      end
   endtask

   int          lat;
   logic        b1;
   int          rd0, wr0, dn0;
   logic [31:0] exp_ck;

   initial begin
      // Reset state
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_count", xfer_count, 32'd0);
      chk("rst_rd_en", mem_read_en, 1'b0);
      chk("rst_wr_en", mem_write_en, 1'b0);
      chk("rst_checksum", checksum, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Basic 4-word copy
      for (int i = 0; i < 4; i++) poke(16'(i), 32'(i + 1));
      rd0 = rd_total; wr0 = wr_total;
      run(32'd0, 32'd100, 32'd4, lat, b1);
      chk("t1_busy_t1", b1, 1'b1);
      chk("t1_latency", lat, 6);
      chk("t1_err", err, 1'b0);
      chk("t1_count", xfer_count, 32'd4);
      @(negedge clk);
      chk("t1_busy_after", busy, 1'b0);
      for (int i = 0; i < 4; i++) chk("t1_mem", mem[100 + i], 32'(i + 1));
      chk("t1_reads", rd_total - rd0, 4);
      chk("t1_writes", wr_total - wr0, 4);

      // Zero length
      rd0 = rd_total; wr0 = wr_total;
      run(32'd5, 32'd200, 32'd0, lat, b1);
      chk("t2_latency", lat, 1);
      chk("t2_err", err, 1'b0);
      chk("t2_count", xfer_count, 32'd0);
      @(negedge clk);
      chk("t2_reads", rd_total - rd0, 0);
      chk("t2_writes", wr_total - wr0, 0);

      // Range error and forward-overlap error
      rd0 = rd_total; wr0 = wr_total;
      run(32'd65530, 32'd0, 32'd10, lat, b1);
      chk("t3_range_latency", lat, 1);
      chk("t3_range_err", err, 1'b1);
      run(32'd10, 32'd12, 32'd5, lat, b1);
      chk("t3_ovl_latency", lat, 1);
      chk("t3_ovl_err", err, 1'b1);
      @(negedge clk);
      chk("t3_err_after", err, 1'b0);
      chk("t3_reads", rd_total - rd0, 0);
      chk("t3_writes", wr_total - wr0, 0);

      // Source ending exactly at the top of memory is legal
      for (int i = 0; i < 4; i++) poke(16'(65532 + i), 32'hBEEF_0000 + 32'(i));
      run(32'd65532, 32'd300, 32'd4, lat, b1);
      chk("t3_edge_latency", lat, 6);
      chk("t3_edge_err", err, 1'b0);
      @(negedge clk);
      chk("t3_edge_mem", mem[303], 32'hBEEF_0003);

      // Backward overlap
      for (int i = 10; i < 28; i++) poke(16'(i), 32'hA000 + 32'(i));
      run(32'd20, 32'd10, 32'd8, lat, b1);
      chk("t4_latency", lat, 10);
      chk("t4_err", err, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 8; i++) chk("t4_mem", mem[10 + i], 32'hA000 + 32'(20 + i));

      // Abort during cycle T+5: reads T+1..T+5, drain T+6, done T+7
      poke(16'd0, 32'h0000_0011);
      poke(16'd1005, 32'h0000_DEAD);
      rd0 = rd_total; wr0 = wr_total;
      @(negedge clk);
      start = 1'b1; src_addr = 32'd0; dst_addr = 32'd1000; len = 32'd100;
      @(negedge clk);            // T+1
      start = 1'b0; lat = 1;
      @(negedge clk);            // T+2: start while busy must be ignored
      start = 1'b1; src_addr = 32'd50; dst_addr = 32'd3000; len = 32'd3; lat++;
      @(negedge clk);            // T+3
      start = 1'b0; lat++;
      @(negedge clk); lat++;     // T+4
      @(negedge clk); lat++;     // T+5
      abort = 1'b1;
      @(negedge clk); lat++;     // T+6
      abort = 1'b0;
      while (done !== 1'b1 && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      chk("t5_latency", lat, 7);
      chk("t5_err", err, 1'b0);
      chk("t5_count", xfer_count, 32'd5);
      @(negedge clk);
      chk("t5_reads", rd_total - rd0, 5);
      chk("t5_writes", wr_total - wr0, 5);
      chk("t5_mem_first", mem[1000], 32'h0000_0011);
      chk("t5_mem_last", mem[1004], mem[4]);
      chk("t5_mem_untouched", mem[1005], 32'h0000_DEAD);
      repeat (3) @(negedge clk);
      chk("t5_busy_idle", busy, 1'b0);
      chk("t5_count_hold", xfer_count, 32'd5);

      // Checksum wraps modulo 2^32
      poke(16'd40, 32'h0000_0001);
      poke(16'd41, 32'hFFFF_FFFF);
      poke(16'd42, 32'h0000_0010);
      run(32'd40, 32'd500, 32'd3, lat, b1);
      chk("t6_latency", lat, 5);
      @(negedge clk);
`ifdef MEM_COPY_CHECKSUM_EN
      exp_ck = 32'h0000_0010;
`else
      exp_ck = 32'h0000_0000;
`endif
      chk("t6_checksum", checksum, exp_ck);
      chk("t6_mem", mem[501], 32'hFFFF_FFFF);

      // Reset mid-copy abandons the command
      @(negedge clk);
      start = 1'b1; src_addr = 32'd0; dst_addr = 32'd2000; len = 32'd50;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      dn0 = done_total;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_rd_en", mem_read_en, 1'b0);
      chk("t6_rst_wr_en", mem_write_en, 1'b0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_count", xfer_count, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("t6_no_done", done_total, dn0);
      chk("t6_idle", busy, 1'b0);
      run(32'd0, 32'd3000, 32'd2, lat, b1);
      chk("t6_recover_latency", lat, 4);
      chk("t6_recover_count", xfer_count, 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
